seg7_shift_ctrl: RTL and testbench

SEG7_SHIFT_CTRL -- requirements
Module: seg7_shift_ctrl

---
 rtl/seg7_shift_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seg7_shift_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_shift_ctrl.sv
// Serial refresh controller for a chain of shift-register-driven 7-segment digits.
// Optional flashing of selected digits is built only when SEG7_FLASH_EN is defined.
module seg7_shift_ctrl #(
   parameter int DIGITS  = 8,
   parameter int CLK_DIV = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   hexs,
   input  logic                  raw_mode,
   input  logic [8*DIGITS-1:0]   raw,
   input  logic [DIGITS-1:0]     point,
   input  logic [DIGITS-1:0]     les,
   input  logic [DIGITS-1:0]     flash_mask,
   input  logic                  flash_tick,
   output logic                  seg_clk,
   output logic                  seg_sout,
   output logic                  seg_pen,
   output logic                  seg_clrn,
   output logic                  busy,
   output logic                  done
);

   localparam int FRAME_W = 8 * DIGITS;
   localparam int DIV_W   = $clog2(2 * CLK_DIV);
   localparam int BIT_W   = $clog2(FRAME_W);

   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

   state_t               state, state_next;
   logic [FRAME_W-1:0]   frame, frame_next;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 pending;
   logic                 shift_end;

   // Active-low font: bit0 = a ... bit6 = g, bit7 = dp (off).
   function automatic logic [7:0] hex_font(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_font = 8'hC0;
         4'h1:    hex_font = 8'hF9;
         4'h2:    hex_font = 8'hA4;
         4'h3:    hex_font = 8'hB0;
         4'h4:    hex_font = 8'h99;
         4'h5:    hex_font = 8'h92;
         4'h6:    hex_font = 8'h82;
         4'h7:    hex_font = 8'hF8;
         4'h8:    hex_font = 8'h80;
         4'h9:    hex_font = 8'h90;
         4'hA:    hex_font = 8'h88;
         4'hB:    hex_font = 8'h83;
         4'hC:    hex_font = 8'hC6;
         4'hD:    hex_font = 8'hA1;
         4'hE:    hex_font = 8'h86;
         default: hex_font = 8'h8E;
      endcase
   endfunction

`ifdef SEG7_FLASH_EN
   logic flash_phase;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) flash_phase <= 1'b0;
      else       flash_phase <= flash_phase ^ flash_tick;
   end
`else
   logic unused_flash;
   assign unused_flash = ^{flash_mask, flash_tick};
`endif

   always_comb begin
      // NOTE: default first so every path assigns frame_next and no latch is inferred.
      frame_next = '1;
      for (int i = 0; i < DIGITS; i++) begin
         logic [7:0] b;
         b = raw_mode ? raw[8*i +: 8] : hex_font(hexs[4*i +: 4]);
         if (point[i]) b[7] = 1'b0;
         if (les[i])   b    = 8'hFF;
`ifdef SEG7_FLASH_EN
         if (flash_phase && flash_mask[i]) b = 8'hFF;
`endif
         frame_next[8*i +: 8] = b;
      end
   end

   assign shift_end = (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start || pending) state_next = LOAD;
         LOAD:    state_next = SHIFT;
         SHIFT:   if (shift_end) state_next = LATCH;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         frame    <= '1;
         seg_clk  <= 1'b1;
         seg_sout <= 1'b0;
         seg_pen  <= 1'b0;
         seg_clrn <= 1'b0;
         done     <= 1'b0;
         pending  <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
      end else begin
         seg_clrn <= 1'b1;
         done     <= (state == LATCH);
         seg_pen  <= !(state_next == SHIFT || state_next == LATCH);

         // A start in IDLE (including the done cycle) launches directly; otherwise it is remembered once.
         if (state == IDLE) begin
            if (start || pending) pending <= 1'b0;
         end else if (start) begin
            pending <= 1'b1;
         end

         case (state)
            LOAD: begin
               frame    <= frame_next;
               seg_sout <= frame_next[FRAME_W-1];
               seg_clk  <= 1'b0;
               div_cnt  <= '0;
               bit_cnt  <= '0;
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (bit_cnt != BIT_LAST) begin
                     frame    <= {frame[FRAME_W-2:0], 1'b1};
                     seg_sout <= frame[FRAME_W-2];
                     seg_clk  <= 1'b0;
                     bit_cnt  <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
                  if (div_cnt == DIV_HALF) seg_clk <= 1'b1;
               end
            end
            default: seg_clk <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_shift_ctrl.sv
// Directed bench for seg7_shift_ctrl (DIGITS=8, CLK_DIV=2); bits are captured on rising seg_clk.
// Define SEG7_FLASH_EN for both bench and RTL to exercise the flashing build.
module tb_seg7_shift_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic [31:0] hexs;
   logic        raw_mode;
   logic [63:0] raw;
   logic [7:0]  point, les, flash_mask;
   logic        flash_tick;
   logic        seg_clk, seg_sout, seg_pen, seg_clrn, busy, done;

   int checks = 0;
   int errors = 0;

   logic [127:0] cap_bits;
   int cap_n, busy_n, done_n, penlow_n, clrnlow_n, done_cyc, reload_cyc;

`ifdef SEG7_FLASH_EN
   localparam logic [63:0] FLASH_EXP = 64'hC0F9_A4B0_9992_82FF;
`else
   localparam logic [63:0] FLASH_EXP = 64'hC0F9_A4B0_9992_82F8;
`endif
   localparam logic [63:0] HEX_EXP = 64'hC0F9_A4B0_9992_82F8;

   seg7_shift_ctrl #(.DIGITS(8), .CLK_DIV(2)) dut (
      .clk(clk), .rstn(rstn), .start(start), .hexs(hexs), .raw_mode(raw_mode),
      .raw(raw), .point(point), .les(les), .flash_mask(flash_mask),
      .flash_tick(flash_tick), .seg_clk(seg_clk), .seg_sout(seg_sout),
      .seg_pen(seg_pen), .seg_clrn(seg_clrn), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse start, then observe ncyc cycles; optional scrambling of hexs and extra starts mid-frame.
   task automatic run(input int ncyc, input bit scramble, input bit extra);
      logic prev_clk, prev_busy;
      cap_bits = '0; cap_n = 0; busy_n = 0; done_n = 0; penlow_n = 0; clrnlow_n = 0;
      done_cyc = -1; reload_cyc = -1;
      @(negedge clk);
      start = 1'b1;
      prev_clk = seg_clk;
      prev_busy = busy;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         start = extra && (c == 10 || c == 50 || c == 100);
         if (scramble && c >= 1) hexs = $urandom;
         busy_n += int'(busy);
         done_n += int'(done);
         if (!seg_pen) penlow_n++;
         if (!seg_clrn) clrnlow_n++;
         if (!prev_clk && seg_clk) begin
            cap_bits = {cap_bits[126:0], seg_sout};
            cap_n++;
         end
         if (done && done_cyc < 0) done_cyc = c;
         if (busy && !prev_busy && done_cyc >= 0 && reload_cyc < 0) reload_cyc = c;
         prev_clk = seg_clk;
         prev_busy = busy;
      end
   endtask

   initial begin
      int rises, dsum, guard;
      logic pc;
      rstn = 1'b0; start = 1'b0; hexs = 32'h0123_4567; raw_mode = 1'b0; raw = '0;
      point = '0; les = '0; flash_mask = '0; flash_tick = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_seg_clk", seg_clk, 1);
      check("rst_seg_sout", seg_sout, 0);
      check("rst_seg_pen", seg_pen, 0);
      check("rst_seg_clrn", seg_clrn, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rstn = 1'b1;
      @(negedge clk);
      check("rel_seg_pen", seg_pen, 1);
      check("rel_seg_clrn", seg_clrn, 1);

      // Basic hex frame
      run(270, 1'b0, 1'b0);
      check("hex_bits", cap_bits[63:0], HEX_EXP);
      check("hex_nbits", cap_n, 64);
      check("hex_busy", busy_n, 258);
      check("hex_done", done_n, 1);
      check("hex_pen_low", penlow_n, 257);
      check("hex_clrn", clrnlow_n, 0);

      // Inputs changing during SHIFT must not reach the frame
      run(270, 1'b1, 1'b0);
      check("scr_bits", cap_bits[63:0], HEX_EXP);
      hexs = 32'h0123_4567;

      // Raw mode, point on byte 0, blank on byte 7
      raw_mode = 1'b1;
      raw = 64'h0102_0304_0506_075A;
      point = 8'h01; les = 8'h80;
      run(270, 1'b0, 1'b0);
      check("raw_bits", cap_bits[63:0], 64'hFF02_0304_0506_075A);

      // Hex mode: dp on digit 7, blank overrides dp on digit 0
      raw_mode = 1'b0;
      hexs = 32'h89AB_CDEF;
      point = 8'h81; les = 8'h01;
      run(270, 1'b0, 1'b0);
      check("dp_les_bits", cap_bits[63:0], 64'h0090_8883_C6A1_86FF);
      hexs = 32'h0123_4567; point = '0; les = '0;

      // Three starts during a frame collapse to one pending frame
      run(600, 1'b0, 1'b1);
      check("pend_done", done_n, 2);
      check("pend_busy", busy_n, 516);
      check("pend_nbits", cap_n, 128);
      check("pend_bits", cap_bits, {HEX_EXP, HEX_EXP});
      check("pend_gap", reload_cyc - done_cyc, 1);

      // Reset asserted mid-frame at bit 20
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rises = 0; guard = 0; pc = seg_clk;
      while (rises < 20 && guard < 300) begin
         @(negedge clk);
         if (!pc && seg_clk) rises++;
         pc = seg_clk;
         guard++;
      end
      check("mid_reach_bit20", rises, 20);
      rstn = 1'b0;
      #1;
      check("mid_seg_clk", seg_clk, 1);
      check("mid_seg_sout", seg_sout, 0);
      check("mid_seg_pen", seg_pen, 0);
      check("mid_seg_clrn", seg_clrn, 0);
      check("mid_busy", busy, 0);
      dsum = 0;
      repeat (2) begin
         @(negedge clk);
         dsum += int'(done);
      end
      rstn = 1'b1;
      repeat (5) begin
         @(negedge clk);
         dsum += int'(done);
      end
      check("mid_no_done", dsum, 0);
      check("mid_pen_after", seg_pen, 1);
      run(270, 1'b0, 1'b0);
      check("mid_fresh_bits", cap_bits[63:0], HEX_EXP);
      check("mid_fresh_done", done_n, 1);

      // Flashing: one tick flashes digit 0 (when built in), a second tick restores it
      flash_mask = 8'h01;
      @(negedge clk); flash_tick = 1'b1;
      @(negedge clk); flash_tick = 1'b0;
      run(270, 1'b0, 1'b0);
      check("flash_on_bits", cap_bits[63:0], FLASH_EXP);
      @(negedge clk); flash_tick = 1'b1;
      @(negedge clk); flash_tick = 1'b0;
      run(270, 1'b0, 1'b0);
      check("flash_off_bits", cap_bits[63:0], HEX_EXP);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
